// File: rtl/fp16_div_iter_pkg.sv
// Shared FP16 divider definitions: field widths, the canonical quiet NaN,
// flag bit positions, FSM states and operand classes.
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  localparam logic [15:0] QNAN = 16'h7E00;

  localparam int FLG_INVALID = 4;
  localparam int FLG_DBZ     = 3;
  localparam int FLG_OVF     = 2;
  localparam int FLG_UNF     = 1;
  localparam int FLG_INX     = 0;

  // cnt value of the final restoring-division iteration (13 iterations total)
  localparam logic [3:0] LAST_ITER = 4'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } op_class_t;

endpackage

// File: rtl/fp16_div_iter_if.sv
// en/valid handshake bundle of the iterative FP16 divider.
interface fp16_div_iter_if;
  logic        en;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic [15:0] result;
  logic        valid;
  logic [4:0]  flags;

  modport master (output en, a, b, input ready, result, valid, flags);
  modport slave  (input en, a, b, output ready, result, valid, flags);
endinterface

// File: rtl/fp16_div_iter_classify.sv
// Combinational FP16 operand decoder; denormals (exp==0) are treated as zero.
module fp16_classify
  import fp16_pkg::*;
(
  input  logic [15:0]      op,
  output op_class_t        cls,
  output logic             sign,
  output logic [EXP_W-1:0] exp,
  output logic [MAN_W:0]   man
);

  // Split the fields and derive the operand class
  always_comb begin
    sign = op[15];
    exp  = op[14:10];
    man  = {1'b1, op[9:0]};
    if (op[14:10] == 5'd0) begin
      cls = ZERO;
    end else if (op[14:10] != 5'h1F) begin
      cls = NORM;
    end else if (op[9:0] == 10'd0) begin
      cls = INF;
    end else begin
      cls = NAN;
    end
  end

endmodule

// File: rtl/fp16_div_iter.sv
// Iterative FP16 divider: 13-cycle radix-2 restoring mantissa division,
// then round-to-nearest-even and packing, one result every 15 cycles.
module fp16_div_iter
  import fp16_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fp16_div_iter_if.slave bus
);

  state_t           state_r;
  logic [3:0]       cnt_r;
  logic [12:0]      q_r;
  logic [11:0]      rem_r;
  logic [MAN_W:0]   mb_r;
  logic [EXP_W-1:0] ea_r, eb_r;
  logic             sign_r;
  op_class_t        cls_a_r, cls_b_r;
  logic [15:0]      result_r;
  logic [4:0]       flags_r;
  logic             valid_r, ready_r;

  op_class_t        cls_a_s, cls_b_s;
  logic             sign_a_s, sign_b_s;
  logic [EXP_W-1:0] exp_a_s, exp_b_s;
  logic [MAN_W:0]   man_a_s, man_b_s;

  logic             ge_s;
  logic [11:0]      diff_s;
  logic [9:0]       man_s, man_fin_s;
  logic [10:0]      man_rnd_s;
  logic             guard_s, sticky_s, round_up_s;
  logic signed [6:0] exp_s, exp_rnd_s;
  logic [15:0]      res_s;
  logic [4:0]       flg_s;

  fp16_classify u_cls_a (.op(bus.a), .cls(cls_a_s), .sign(sign_a_s), .exp(exp_a_s), .man(man_a_s));
  fp16_classify u_cls_b (.op(bus.b), .cls(cls_b_s), .sign(sign_b_s), .exp(exp_b_s), .man(man_b_s));

  // One restoring step: the remainder always stays below 2*Mb, so 12 bits suffice
  always_comb begin
    ge_s   = (rem_r >= {1'b0, mb_r});
    diff_s = rem_r;
    if (ge_s) begin
      diff_s = rem_r - {1'b0, mb_r};
    end else begin
      diff_s = rem_r;
    end
  end

  // Normalise the quotient, pick guard/sticky and round to nearest-even
  always_comb begin
    man_s    = 10'd0;
    guard_s  = 1'b0;
    sticky_s = 1'b0;
    exp_s    = 7'sd0;
    if (q_r[12]) begin
      man_s    = q_r[11:2];
      guard_s  = q_r[1];
      sticky_s = q_r[0] | (rem_r != 12'd0);
      exp_s    = {2'b00, ea_r} - {2'b00, eb_r} + 7'(BIAS);
    end else begin
      man_s    = q_r[10:1];
      guard_s  = q_r[0];
      sticky_s = (rem_r != 12'd0);
      exp_s    = {2'b00, ea_r} - {2'b00, eb_r} + 7'(BIAS - 1);
    end
    round_up_s = guard_s & (sticky_s | man_s[0]);
    man_rnd_s  = {1'b0, man_s} + {10'd0, round_up_s};
    if (man_rnd_s[10]) begin
      man_fin_s = 10'd0;
      exp_rnd_s = exp_s + 7'sd1;
    end else begin
      man_fin_s = man_rnd_s[9:0];
      exp_rnd_s = exp_s;
    end
  end

  // Special operands override the arithmetic, in priority order
  always_comb begin
    res_s = 16'h0000;
    flg_s = 5'h00;
    if ((cls_a_r == NAN) || (cls_b_r == NAN) ||
        ((cls_a_r == ZERO) && (cls_b_r == ZERO)) ||
        ((cls_a_r == INF) && (cls_b_r == INF))) begin
      res_s = QNAN;
      flg_s[FLG_INVALID] = 1'b1;
    end else if (cls_a_r == INF) begin
      res_s = {sign_r, 5'h1F, 10'h000};
    end else if (cls_b_r == INF) begin
      res_s = {sign_r, 15'h0000};
    end else if (cls_b_r == ZERO) begin
      res_s = {sign_r, 5'h1F, 10'h000};
      flg_s[FLG_DBZ] = 1'b1;
    end else if (cls_a_r == ZERO) begin
      res_s = {sign_r, 15'h0000};
    end else if (exp_rnd_s >= 7'sd31) begin
      res_s = {sign_r, 5'h1F, 10'h000};
      flg_s[FLG_OVF] = 1'b1;
      flg_s[FLG_INX] = 1'b1;
    end else if (exp_rnd_s <= 7'sd0) begin
      res_s = {sign_r, 15'h0000};
      flg_s[FLG_UNF] = 1'b1;
      flg_s[FLG_INX] = 1'b1;
    end else begin
      res_s = {sign_r, exp_rnd_s[4:0], man_fin_s};
      flg_s[FLG_INX] = guard_s | sticky_s;
    end
  end

  // Control FSM with the iteration datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      result_r <= 16'h0000;
      flags_r  <= 5'h00;
      cnt_r    <= 4'd0;
      q_r      <= 13'd0;
      rem_r    <= 12'd0;
      mb_r     <= 11'd0;
      ea_r     <= 5'd0;
      eb_r     <= 5'd0;
      sign_r   <= 1'b0;
      cls_a_r  <= ZERO;
      cls_b_r  <= ZERO;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.en) begin
            cls_a_r <= cls_a_s;
            cls_b_r <= cls_b_s;
            sign_r  <= sign_a_s ^ sign_b_s;
            ea_r    <= exp_a_s;
            eb_r    <= exp_b_s;
            mb_r    <= man_b_s;
            rem_r   <= {1'b0, man_a_s};
            q_r     <= 13'd0;
            cnt_r   <= 4'd0;
            ready_r <= 1'b0;
            state_r <= DIV;
          end
        end
        DIV: begin
          q_r   <= {q_r[11:0], ge_s};
          rem_r <= diff_s << 1;
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == LAST_ITER) begin
            state_r <= ROUND;
          end
        end
        ROUND: begin
          result_r <= res_s;
          flags_r  <= flg_s;
          valid_r  <= 1'b1;
          ready_r  <= 1'b1;
          state_r  <= IDLE;
        end
        default: begin
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready  = ready_r;
  assign bus.valid  = valid_r;
  assign bus.result = result_r;
  assign bus.flags  = flags_r;

endmodule
